// File: rtl/grey_rx_decoder.sv
// rtl/grey_rx_decoder.sv - Gray-code receive decoder with synchronizer, step tracking and error flags
//
// Purpose: samples a free-running Gray-coded count (possibly from another
// clock domain) through a SYNC_STAGES-deep synchronizer, decodes it to
// binary, pulses step/wrap on each legal +1 advance and keeps a saturating
// count of advances.
//
// Optional feature macro: GREY_RX_ERR_CHECK_EN
//   defined   : Hamming-distance check built; err / err_sticky functional
//   undefined : err and err_sticky tied 0; non +1 changes update bin_out silently
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-low reset
//   gray_in    in   Gray-coded count from the transmitter (WIDTH)
//   clr        in   synchronous clear of err_sticky and step_cnt
//   bin_out    out  registered binary decode of last accepted sample (WIDTH)
//   step       out  one-cycle pulse on a legal +1 advance
//   wrap       out  one-cycle pulse on the 2^WIDTH-1 -> 0 advance
//   err        out  one-cycle pulse on an illegal transition
//   err_sticky out  set by err, held until clr or reset
//   step_cnt   out  saturating count of step pulses (CNT_W)
module grey_rx_decoder #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             step,
  output logic             wrap,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] step_cnt
);

  typedef enum logic {
    ST_UNPRIMED = 1'b0,
    ST_TRACK    = 1'b1
  } state_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] g_bin;
  logic [WIDTH-1:0] bin_inc;
  state_e           state_q;
  logic [WIDTH-1:0] prev_g_q;
  logic [WIDTH-1:0] bin_q;
  logic             step_q;
  logic             wrap_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_d;
  logic             changed;
  logic             inc_match;
  logic             legal;
  logic             step_d;
  logic             wrap_d;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] gv);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = gv[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gv[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g         = sync_q[SYNC_STAGES-1];
  assign g_bin     = gray2bin(g);
  assign bin_inc   = bin_q + WIDTH'(1);
  assign inc_match = (g_bin == bin_inc);
  assign changed   = (state_q == ST_TRACK) && (g != prev_g_q);

`ifdef GREY_RX_ERR_CHECK_EN
  logic [WIDTH-1:0] diff;
  logic             one_bit;
  // Power-of-two test: exactly one bit set in the sample-to-sample difference.
  assign diff    = g ^ prev_g_q;
  assign one_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  assign legal   = one_bit && inc_match;
`else
  assign legal   = inc_match;
`endif

  assign step_d = changed && legal;
  assign wrap_d = step_d && (bin_q == '1);

  // clr is applied before the increment so clr coinciding with step yields 1.
  assign cnt_base = clr ? '0 : cnt_q;
  assign cnt_d    = (step_d && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_UNPRIMED;
      prev_g_q <= '0;
      bin_q    <= '0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (state_q == ST_UNPRIMED) begin
        // Priming: adopt whatever the synchronizer holds, no classification.
        prev_g_q <= g;
        bin_q    <= g_bin;
        state_q  <= ST_TRACK;
      end else if (changed) begin
        // Always resync to the new sample, legal or not.
        prev_g_q <= g;
        bin_q    <= g_bin;
        step_q   <= step_d;
        wrap_q   <= wrap_d;
      end
      cnt_q <= cnt_d;
    end
  end

`ifdef GREY_RX_ERR_CHECK_EN
  logic err_d;
  logic err_q;
  logic sticky_q;

  assign err_d = changed && !legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      err_q    <= err_d;
      // Set beats clear.
      sticky_q <= err_d | (sticky_q & ~clr);
    end
  end

  assign err        = err_q;
  assign err_sticky = sticky_q;
`else
  assign err        = 1'b0;
  assign err_sticky = 1'b0;
`endif

  assign bin_out  = bin_q;
  assign step     = step_q;
  assign wrap     = wrap_q;
  assign step_cnt = cnt_q;

endmodule
